// File: rtl/tristate_bus_driver.sv
// Sequencer for a bank of tri-state pad buffers on a shared half-duplex bus.
// Writes run SETUP -> DRIVE -> TURN; reads wait in SAMPLE, then capture PAD_I.
module tristate_bus_driver #(
  parameter int WIDTH      = 8,
  parameter int SETUP_CYC  = 1,
  parameter int DRIVE_CYC  = 4,
  parameter int TURN_CYC   = 2,
  parameter int SAMPLE_CYC = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [WIDTH-1:0] pad_o,
  output logic             pad_t,
  input  logic [WIDTH-1:0] pad_i
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DRIVE,
    ST_TURN,
    ST_SAMPLE
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LD  = (SETUP_CYC > 0) ? CNT_W'(SETUP_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] DRIVE_LD  = CNT_W'(DRIVE_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD   = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYC - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             cnt_zero;
  logic             can_accept;
  logic             accept;
  logic             capture;

  logic             req_ready_reg;
  logic             busy_reg;
  logic             pad_t_reg;
  logic             rsp_valid_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [WIDTH-1:0] pad_o_reg;

  assign cnt_zero = (cnt_reg == '0);

  // The last cycle of any operation hands straight over to a waiting request,
  // giving back-to-back throughput equal to the stated occupancy.
  always_comb begin
    can_accept = 1'b0;
    case (state_reg)
      ST_IDLE:   can_accept = 1'b1;
      ST_DRIVE:  can_accept = cnt_zero && (TURN_CYC == 0);
      ST_TURN:   can_accept = cnt_zero;
      ST_SAMPLE: can_accept = cnt_zero;
      default:   can_accept = 1'b0;
    endcase
  end

  assign accept  = req_valid && can_accept;
  assign capture = (state_reg == ST_SAMPLE) && cnt_zero;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_zero ? cnt_reg : cnt_reg - CNT_W'(1);
    if (accept) begin
      if (!req_write) begin
        state_next = ST_SAMPLE;
        cnt_next   = SAMPLE_LD;
      end else if (SETUP_CYC > 0) begin
        state_next = ST_SETUP;
        cnt_next   = SETUP_LD;
      end else begin
        state_next = ST_DRIVE;
        cnt_next   = DRIVE_LD;
      end
    end else if (cnt_zero) begin
      case (state_reg)
        ST_SETUP: begin
          state_next = ST_DRIVE;
          cnt_next   = DRIVE_LD;
        end
        ST_DRIVE: begin
          if (TURN_CYC > 0) begin
            state_next = ST_TURN;
            cnt_next   = TURN_LD;
          end else begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        end
        ST_TURN, ST_SAMPLE: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
        default: begin
          state_next = state_reg;
          cnt_next   = cnt_reg;
        end
      endcase
    end
  end

  // Pin-facing outputs are flops fed by the next state, so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      req_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      pad_t_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      req_ready_reg <= (state_next == ST_IDLE);
      busy_reg      <= (state_next != ST_IDLE);
      pad_t_reg     <= (state_next != ST_DRIVE);
      rsp_valid_reg <= capture;
      if (capture) begin
        rsp_data_reg <= pad_i;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pad_o
      always_ff @(posedge clk) begin
        if (rst) begin
          pad_o_reg[gi] <= 1'b0;
        end else if (accept && req_write) begin
          pad_o_reg[gi] <= req_data[gi];
        end
      end
    end
  endgenerate

  assign req_ready = req_ready_reg;
  assign busy      = busy_reg;
  assign pad_t     = pad_t_reg;
  assign pad_o     = pad_o_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_tristate_bus_driver.sv
// Directed bench for tristate_bus_driver: default timing plus a minimal-timing instance.
module tb_tristate_bus_driver;

  logic       clk = 1'b0;
  logic       rst;

  logic       req_valid, req_write;
  logic [7:0] req_data, pad_i;
  logic       req_ready, rsp_valid, busy, pad_t;
  logic [7:0] rsp_data, pad_o;

  logic       f_req_valid, f_req_write;
  logic [7:0] f_req_data, f_pad_i;
  logic       f_req_ready, f_rsp_valid, f_busy, f_pad_t;
  logic [7:0] f_rsp_data, f_pad_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tristate_bus_driver u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .pad_o(pad_o), .pad_t(pad_t), .pad_i(pad_i)
  );

  tristate_bus_driver #(.SETUP_CYC(0), .DRIVE_CYC(1), .TURN_CYC(0)) u_fast (
    .clk(clk), .rst(rst),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write), .req_data(f_req_data),
    .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data), .busy(f_busy),
    .pad_o(f_pad_o), .pad_t(f_pad_t), .pad_i(f_pad_i)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, obs, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_data = 0; pad_i = 0;
    f_req_valid = 0; f_req_write = 0; f_req_data = 0; f_pad_i = 0;
    tick(); tick();
    check_val("rst_ready", req_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_pad_t", pad_t, 1);
    check_val("rst_pad_o", pad_o, 8'h00);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_data", rsp_data, 8'h00);
    rst = 1'b0;
    tick();

    // Write 0xA5: setup, drive x4, turn x2, idle
    req_valid = 1; req_write = 1; req_data = 8'hA5;
    tick();
    req_valid = 0; req_data = 8'h00;
    check_val("wr_c0_pad_o", pad_o, 8'hA5);
    check_val("wr_c0_pad_t", pad_t, 1);
    check_val("wr_c0_ready", req_ready, 0);
    check_val("wr_c0_busy", busy, 1);
    for (int n = 1; n <= 4; n++) begin
      tick();
      check_val($sformatf("wr_c%0d_pad_t", n), pad_t, 0);
    end
    for (int n = 5; n <= 6; n++) begin
      tick();
      check_val($sformatf("wr_c%0d_pad_t", n), pad_t, 1);
      check_val($sformatf("wr_c%0d_ready", n), req_ready, 0);
    end
    tick();
    check_val("wr_c7_ready", req_ready, 1);
    check_val("wr_c7_busy", busy, 0);
    check_val("wr_c7_pad_o", pad_o, 8'hA5);

    // Read with PAD_I=0x3C
    pad_i = 8'h3C;
    req_valid = 1; req_write = 0;
    tick();
    req_valid = 0;
    for (int n = 0; n <= 2; n++) begin
      check_val($sformatf("rd_c%0d_pad_t", n), pad_t, 1);
      check_val($sformatf("rd_c%0d_rsp_valid", n), rsp_valid, 0);
      tick();
    end
    check_val("rd_c3_rsp_valid", rsp_valid, 1);
    check_val("rd_c3_rsp_data", rsp_data, 8'h3C);
    check_val("rd_c3_ready", req_ready, 1);
    check_val("rd_c3_pad_o", pad_o, 8'hA5);
    tick();
    check_val("rd_c4_rsp_valid", rsp_valid, 0);
    check_val("rd_c4_rsp_data", rsp_data, 8'h3C);

    // Back-to-back: write 0x11, then a read held on VALID
    req_valid = 1; req_write = 1; req_data = 8'h11;
    tick();
    req_write = 0; req_data = 8'hEE; pad_i = 8'h5A;
    check_val("b2b_c0_pad_t", pad_t, 1);
    for (int n = 1; n <= 4; n++) begin
      tick();
      check_val($sformatf("b2b_c%0d_pad_t", n), pad_t, 0);
      check_val($sformatf("b2b_c%0d_ready", n), req_ready, 0);
    end
    tick(); tick();
    check_val("b2b_c6_pad_t", pad_t, 1);
    tick();
    req_valid = 0;
    check_val("b2b_c7_ready", req_ready, 0);
    check_val("b2b_c7_pad_t", pad_t, 1);
    check_val("b2b_c7_pad_o", pad_o, 8'h11);
    tick(); tick();
    check_val("b2b_c9_rsp_valid", rsp_valid, 0);
    tick();
    check_val("b2b_c10_rsp_valid", rsp_valid, 1);
    check_val("b2b_c10_rsp_data", rsp_data, 8'h5A);
    check_val("b2b_c10_pad_o", pad_o, 8'h11);
    tick();

    // Two reads with VALID held: second accepted as the first response rises
    req_valid = 1; req_write = 0; pad_i = 8'h77;
    tick();
    tick(); tick(); tick();
    req_valid = 0; pad_i = 8'h88;
    check_val("rr_c3_rsp_valid", rsp_valid, 1);
    check_val("rr_c3_rsp_data", rsp_data, 8'h77);
    check_val("rr_c3_ready", req_ready, 0);
    tick();
    check_val("rr_c4_rsp_valid", rsp_valid, 0);
    tick(); tick();
    check_val("rr_c6_rsp_valid", rsp_valid, 1);
    check_val("rr_c6_rsp_data", rsp_data, 8'h88);
    tick();

    // Reset at E1 of a read: no response, data cleared
    req_valid = 1; req_write = 0; pad_i = 8'hC3;
    tick();
    req_valid = 0; rst = 1;
    tick();
    rst = 0;
    check_val("rrst_c1_rsp_data", rsp_data, 8'h00);
    check_val("rrst_c1_ready", req_ready, 1);
    for (int n = 2; n <= 6; n++) begin
      tick();
      check_val($sformatf("rrst_c%0d_rsp_valid", n), rsp_valid, 0);
    end
    check_val("rrst_end_rsp_data", rsp_data, 8'h00);

    // Reset at E3 of a write: bus released immediately
    req_valid = 1; req_write = 1; req_data = 8'h5C;
    tick();
    req_valid = 0;
    tick(); tick();
    check_val("wrst_c2_pad_t", pad_t, 0);
    rst = 1;
    tick();
    rst = 0;
    check_val("wrst_c3_pad_t", pad_t, 1);
    check_val("wrst_c3_pad_o", pad_o, 8'h00);
    check_val("wrst_c3_ready", req_ready, 1);
    check_val("wrst_c3_busy", busy, 0);
    for (int n = 4; n <= 7; n++) begin
      tick();
      check_val($sformatf("wrst_c%0d_pad_t", n), pad_t, 1);
    end

    // Minimal timing: SETUP=0, DRIVE=1, TURN=0
    f_req_valid = 1; f_req_write = 1; f_req_data = 8'hFF;
    tick();
    f_req_valid = 0;
    check_val("fast_c0_pad_t", f_pad_t, 0);
    check_val("fast_c0_pad_o", f_pad_o, 8'hFF);
    check_val("fast_c0_ready", f_req_ready, 0);
    tick();
    check_val("fast_c1_pad_t", f_pad_t, 1);
    check_val("fast_c1_ready", f_req_ready, 1);
    check_val("fast_c1_pad_o", f_pad_o, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
